// File: rtl/log2_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : log2_arbiter_if
// Brief    : Request/result bundle for the shared log2 datapath arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface log2_arbiter_if #(
   parameter int NUM_REQ   = 4,
   parameter int FRAC_BITS = 4
);
   localparam int IDW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]    req_valid_i;
   logic [NUM_REQ*32-1:0] req_data_i;
   logic [NUM_REQ-1:0]    req_ready_o;
   logic                  res_valid_o;
   logic                  res_ready_i;
   logic [4+FRAC_BITS:0]  res_log_o;
   logic [IDW-1:0]        res_id_o;
   logic                  res_zero_o;

   modport master (
      output req_valid_i, req_data_i, res_ready_i,
      input  req_ready_o, res_valid_o, res_log_o, res_id_o, res_zero_o
   );

   modport slave (
      input  req_valid_i, req_data_i, res_ready_i,
      output req_ready_o, res_valid_o, res_log_o, res_id_o, res_zero_o
   );
endinterface
`default_nettype wire

// File: rtl/log2_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : log2_arbiter
// Brief    : Round-robin arbiter feeding a two-stage fixed-point log2 pipe.
// Revision : 1.0  initial release
// ============================================================================
module log2_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int FRAC_BITS = 4
) (
   input  wire logic     clk,
   input  wire logic     rst_n,
   log2_arbiter_if.slave bus
);
   localparam int             IDW    = $clog2(NUM_REQ);
   localparam logic [IDW-1:0] c_last = IDW'(NUM_REQ - 1);

   logic [IDW-1:0]     r_ptr;
   logic               r_s1_valid;
   logic [31:0]        r_s1_data;
   logic [IDW-1:0]     r_s1_id;
   logic               r_res_valid;
   logic [4+FRAC_BITS:0] r_res_log;
   logic [IDW-1:0]     r_res_id;
   logic               r_res_zero;

   logic [31:0]        w_req_data [NUM_REQ];
   logic [IDW-1:0]     w_idx;
   logic [IDW-1:0]     w_gnt_id;
   logic               w_any;
   logic [31:0]        w_gnt_data;
   logic               w_s1_adv;
   logic               w_s2_adv;
   logic               w_accept;
   logic [NUM_REQ-1:0] w_ready;
   logic [4:0]         w_msb;
   logic [FRAC_BITS-1:0] w_frac;
   logic               w_zero;

   generate
      for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
         assign w_req_data[g] = bus.req_data_i[32*g +: 32];
      end
   endgenerate

   // Scan starts at the pointer and wraps, so the first hit is the round-robin winner.
   always_comb begin
      w_any    = 1'b0;
      w_gnt_id = '0;
      w_idx    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_idx = IDW'((int'(r_ptr) + i) % NUM_REQ);
         if (!w_any && bus.req_valid_i[w_idx]) begin
            w_any    = 1'b1;
            w_gnt_id = w_idx;
         end
      end
   end

   assign w_gnt_data = w_req_data[w_gnt_id];
   assign w_s2_adv   = !r_res_valid || bus.res_ready_i;
   assign w_s1_adv   = !r_s1_valid || w_s2_adv;
   assign w_accept   = rst_n && w_any && w_s1_adv;

   always_comb begin
      w_ready = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_ready[k] = w_accept && (w_gnt_id == IDW'(k));
      end
   end

   // Leading-one position gives the integer part; bits just below it are the fraction.
   always_comb begin
      w_msb = '0;
      for (int b = 0; b < 32; b++) begin
         if (r_s1_data[b]) w_msb = 5'(b);
      end
      w_zero = (r_s1_data == 32'd0);
      w_frac = FRAC_BITS'((r_s1_data << (5'd31 - w_msb)) >> (31 - FRAC_BITS));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ptr       <= '0;
         r_s1_valid  <= 1'b0;
         r_s1_data   <= '0;
         r_s1_id     <= '0;
         r_res_valid <= 1'b0;
         r_res_log   <= '0;
         r_res_id    <= '0;
         r_res_zero  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_ptr <= (w_gnt_id == c_last) ? '0 : w_gnt_id + IDW'(1);
         end
         if (w_s1_adv) begin
            r_s1_valid <= w_accept;
            r_s1_data  <= w_gnt_data;
            r_s1_id    <= w_gnt_id;
         end
         if (w_s2_adv) begin
            r_res_valid <= r_s1_valid;
            r_res_log   <= {w_msb, w_frac};
            r_res_id    <= r_s1_id;
            r_res_zero  <= w_zero;
         end
      end
   end

   assign bus.req_ready_o = w_ready;
   assign bus.res_valid_o = r_res_valid;
   assign bus.res_log_o   = r_res_log;
   assign bus.res_id_o    = r_res_id;
   assign bus.res_zero_o  = r_res_zero;

   a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(bus.req_ready_o));
   a_grant_valid: assert property (@(posedge clk) disable iff (!rst_n)
      (bus.req_ready_o & ~bus.req_valid_i) == '0);
endmodule
`default_nettype wire

// File: tb/tb_log2_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_log2_arbiter
// Brief    : Scoreboard bench for log2_arbiter with hand-computed vectors.
// Revision : 1.0  initial release
// ============================================================================
module tb_log2_arbiter;
   localparam int NUM_REQ   = 4;
   localparam int FRAC_BITS = 4;

   typedef struct packed {
      logic [1:0] id;
      logic [8:0] lg;
      logic       zero;
   } res_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   log2_arbiter_if #(.NUM_REQ(NUM_REQ), .FRAC_BITS(FRAC_BITS)) bus ();

   log2_arbiter #(.NUM_REQ(NUM_REQ), .FRAC_BITS(FRAC_BITS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [31:0]        vec_data [12];
   logic [8:0]         vec_log  [12];
   logic [11:0]        vec_zero;
   logic [31:0]        opbuf [NUM_REQ][32];
   int                 oph [NUM_REQ];
   int                 opt [NUM_REQ];
   res_t               sb [$];
   res_t               exp_r;
   logic [NUM_REQ-1:0] acc_mask = '0;
   int                 vectors     = 0;
   int                 miscompares = 0;
   int                 cyc         = 0;
   int                 nres        = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_op(input int k, input int v, input bit expect_res);
      res_t e;
      opbuf[k][opt[k]] = vec_data[v];
      opt[k]++;
      if (expect_res) begin
         e.id   = 2'(k);
         e.lg   = vec_log[v];
         e.zero = vec_zero[v];
         sb.push_back(e);
      end
   endtask

   // Inputs only change here, just after a rising edge.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (acc_mask[k]) oph[k]++;
         if (oph[k] != opt[k]) begin
            bus.req_valid_i[k]           = 1'b1;
            bus.req_data_i[32*k +: 32]   = opbuf[k][oph[k]];
         end else begin
            bus.req_valid_i[k]           = 1'b0;
            bus.req_data_i[32*k +: 32]   = '0;
         end
      end
   endtask

   function automatic bit idle();
      if (sb.size() != 0) return 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (oph[k] != opt[k]) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic drain(input string name, input int max);
      int n = 0;
      while (!idle() && n < max) begin
         step();
         @(negedge clk);
         #1;
         n++;
      end
      check({name, "_drain"}, 32'(idle()), 32'd1);
   endtask

   // Monitor: records accepts for the driver and checks results in order.
   always @(negedge clk) begin
      acc_mask = rst_n ? (bus.req_valid_i & bus.req_ready_o) : '0;
      if (rst_n && bus.res_valid_o && bus.res_ready_i) begin
         nres++;
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_result: got id %0d log 0x%0h zero %0d, required none (cycle %0d)",
                     bus.res_id_o, bus.res_log_o, bus.res_zero_o, cyc);
         end else begin
            exp_r = sb.pop_front();
            check($sformatf("result%0d", nres),
                  32'({bus.res_id_o, bus.res_log_o, bus.res_zero_o}), 32'(exp_r));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int nacc;
      int c0;
      int first;
      int last;
      int n;

      vec_data = '{32'h00000001, 32'h00000300, 32'h80000000, 32'h0000000F,
                   32'h00000000, 32'h12345678, 32'hFFFFFFFF, 32'h00010000,
                   32'h000000A0, 32'h00000003, 32'h00000005, 32'h0000FFFF};
      vec_log  = '{9'h000, 9'h098, 9'h1F0, 9'h03E, 9'h000, 9'h1C2,
                   9'h1FF, 9'h100, 9'h074, 9'h018, 9'h024, 9'h0FF};
      vec_zero = 12'h010;
      for (int k = 0; k < NUM_REQ; k++) begin
         oph[k] = 0;
         opt[k] = 0;
      end
      bus.req_valid_i = '0;
      bus.req_data_i  = '0;
      bus.res_ready_i = 1'b1;
      rst_n           = 1'b0;

      // Reset state, then a single operand from requester 2
      push_op(2, 0, 1'b1);
      step();
      step();
      @(negedge clk);
      check("reset_res_valid", 32'(bus.res_valid_o), 32'd0);
      check("reset_res_log",   32'(bus.res_log_o),   32'd0);
      check("reset_res_id",    32'(bus.res_id_o),    32'd0);
      check("reset_res_zero",  32'(bus.res_zero_o),  32'd0);
      check("reset_ready",     32'(bus.req_ready_o), 32'd0);
      step();
      rst_n = 1'b1;
      @(negedge clk);
      check("first_grant", 32'(bus.req_ready_o), 32'b0100);
      step();
      @(negedge clk);
      check("latency_s1", 32'(bus.res_valid_o), 32'd0);
      step();
      @(negedge clk);
      check("latency_out", 32'(bus.res_valid_o), 32'd1);
      drain("single", 20);

      // Fraction extraction
      for (int v = 1; v <= 4; v++) push_op(0, v, 1'b1);
      drain("fraction", 30);

      // Fairness from a fresh pointer
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < NUM_REQ; k++) push_op(k, r*4 + k, 1'b1);
      end
      c0    = cyc;
      first = -1;
      last  = -1;
      n     = 0;
      for (int i = 0; i < 40 && n < 12; i++) begin
         step();
         @(negedge clk);
         if (bus.res_valid_o && bus.res_ready_i) begin
            if (first < 0) first = cyc;
            n++;
            if (n == 12) last = cyc;
         end
      end
      check("fairness_fill", 32'(first - c0), 32'd3);
      check("fairness_rate", 32'(last - first + 1), 32'd12);
      drain("fairness", 20);

      // Backpressure on a requester-1 stream
      step();
      bus.res_ready_i = 1'b0;
      for (int v = 5; v <= 10; v++) push_op(1, v, 1'b1);
      nacc = 0;
      for (int i = 1; i <= 5; i++) begin
         step();
         @(negedge clk);
         if (bus.req_valid_i[1] && bus.req_ready_o[1]) nacc++;
         if (i >= 3) begin
            check("stall_valid", 32'(bus.res_valid_o), 32'd1);
            check("stall_hold", 32'({bus.res_id_o, bus.res_log_o, bus.res_zero_o}),
                  32'({2'd1, 9'h1C2, 1'b0}));
         end
      end
      check("stall_accepts", 32'(nacc), 32'd2);
      check("stall_ready", 32'(bus.req_ready_o), 32'd0);
      step();
      bus.res_ready_i = 1'b1;
      @(negedge clk);
      check("no_bubble", 32'(bus.req_ready_o), 32'b0010);
      drain("backpressure", 30);

      // Sparse round-robin: pointer sits at 2, so 3 wins first
      push_op(3, 7, 1'b1);
      push_op(1, 8, 1'b1);
      push_op(3, 9, 1'b1);
      push_op(1, 11, 1'b1);
      drain("sparse", 30);

      // Reset with both stages full; those operands must vanish
      step();
      bus.res_ready_i = 1'b0;
      push_op(2, 6, 1'b0);
      push_op(2, 7, 1'b0);
      push_op(2, 8, 1'b0);
      step();
      step();
      step();
      @(negedge clk);
      check("full_res_valid", 32'(bus.res_valid_o), 32'd1);
      check("full_ready",     32'(bus.req_ready_o), 32'd0);
      step();
      rst_n = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) oph[k] = opt[k];
      @(negedge clk);
      check("midreset_ready", 32'(bus.req_ready_o), 32'd0);
      step();
      rst_n           = 1'b1;
      bus.res_ready_i = 1'b1;
      @(negedge clk);
      check("midreset_res_valid", 32'(bus.res_valid_o), 32'd0);
      push_op(1, 9, 1'b1);
      push_op(3, 10, 1'b1);
      drain("restart", 30);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire
